// File: rtl/tft_pixel_stream.sv
// Pixel word FIFO and raster-position tracker that feeds the TFT SPI serializer.
// Each rising edge of the slow data_clk strobe (sampled in clk) issues one word on pixel_out.
module tft_pixel_stream #(
   parameter int unsigned WIDTH  = 128,
   parameter int unsigned HEIGHT = 160,
   parameter int unsigned DEPTH  = 16,
   parameter logic [15:0] FILL   = 16'h0000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      data_clk,
   input  logic                      enable,
   input  logic                      resync,
   input  logic                      wr_en,
   input  logic [15:0]               wr_data,
   input  logic                      clear_flags,
   output logic [15:0]               pixel_out,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    level,
   output logic [$clog2(WIDTH)-1:0]  x,
   output logic [$clog2(HEIGHT)-1:0] y,
   output logic                      frame_start,
   output logic                      overflow,
   output logic                      underrun
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned XW = $clog2(WIDTH);
   localparam int unsigned YW = $clog2(HEIGHT);

   localparam logic [LW-1:0] LevelFull = LW'(DEPTH);
   localparam logic [XW-1:0] XLast     = XW'(WIDTH - 1);
   localparam logic [YW-1:0] YLast     = YW'(HEIGHT - 1);

   // sync_q[0] = s1, sync_q[1] = s2, sync_q[2] = s3 (edge history)
   logic [2:0]    sync_q;

   logic [15:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;

   logic [15:0]   pixel_q, pixel_d;
   logic [XW-1:0] x_q, x_d, nx_q, nx_d;
   logic [YW-1:0] y_q, y_d, ny_q, ny_d;
   logic          frame_start_q, frame_start_d;
   logic          overflow_q, overflow_d;
   logic          underrun_q, underrun_d;

   logic          strobe;
   logic          issue;
   logic          pop;
   logic          wr_accept;
   logic          wr_drop;
   logic          is_full;
   logic          is_empty;

   assign is_full  = (level_q == LevelFull);
   assign is_empty = (level_q == '0);

   assign strobe    = sync_q[1] & ~sync_q[2];
   assign issue     = strobe & enable & ~resync;
   assign pop       = issue & ~is_empty;
   assign wr_accept = wr_en & ~is_full & ~resync;
   assign wr_drop   = wr_en & is_full & ~resync;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[1:0], data_clk};
      end
   end

   // Storage needs no reset; level/pointers define which entries are valid.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (resync) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         unique case ({wr_accept, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
      end
   end

   // Issue path: the pop sees the pre-write FIFO state, so an empty FIFO emits FILL.
   always_comb begin
      pixel_d       = pixel_q;
      x_d           = x_q;
      y_d           = y_q;
      nx_d          = nx_q;
      ny_d          = ny_q;
      frame_start_d = 1'b0;
      if (resync) begin
         nx_d = '0;
         ny_d = '0;
      end else if (issue) begin
         pixel_d       = is_empty ? FILL : mem_q[rd_ptr_q];
         x_d           = nx_q;
         y_d           = ny_q;
         frame_start_d = (nx_q == '0) && (ny_q == '0);
         if (nx_q == XLast) begin
            nx_d = '0;
            ny_d = (ny_q == YLast) ? '0 : ny_q + YW'(1);
         end else begin
            nx_d = nx_q + XW'(1);
         end
      end
   end

   // A set event in the same cycle as clear_flags takes priority.
   always_comb begin
      overflow_d = overflow_q;
      underrun_d = underrun_q;
      if (clear_flags) begin
         overflow_d = 1'b0;
         underrun_d = 1'b0;
      end
      if (wr_drop) begin
         overflow_d = 1'b1;
      end
      if (issue && is_empty) begin
         underrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         level_q       <= '0;
         pixel_q       <= '0;
         x_q           <= '0;
         y_q           <= '0;
         nx_q          <= '0;
         ny_q          <= '0;
         frame_start_q <= 1'b0;
         overflow_q    <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         level_q       <= level_d;
         pixel_q       <= pixel_d;
         x_q           <= x_d;
         y_q           <= y_d;
         nx_q          <= nx_d;
         ny_q          <= ny_d;
         frame_start_q <= frame_start_d;
         overflow_q    <= overflow_d;
         underrun_q    <= underrun_d;
      end
   end

   assign pixel_out   = pixel_q;
   assign full        = is_full;
   assign empty       = is_empty;
   assign level       = level_q;
   assign x           = x_q;
   assign y           = y_q;
   assign frame_start = frame_start_q;
   assign overflow    = overflow_q;
   assign underrun    = underrun_q;

endmodule

// File: tb/tb_tft_pixel_stream.sv
// Self-checking bench for tft_pixel_stream: directed scenarios plus a randomized
// sequence, compared against a queue-based reference model of the pixel stream.
module tb_tft_pixel_stream;

   localparam int unsigned WIDTH  = 4;
   localparam int unsigned HEIGHT = 2;
   localparam int unsigned DEPTH  = 16;
   localparam logic [15:0] FILL   = 16'h5A5A;

   logic        clk = 1'b0;
   logic        rst, data_clk, enable, resync, wr_en, clear_flags;
   logic [15:0] wr_data;
   logic [15:0] pixel_out;
   logic        full, empty, frame_start, overflow, underrun;
   logic [4:0]  level;
   logic [1:0]  x;
   logic [0:0]  y;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [15:0] mq[$];
   logic [15:0] m_pix;
   int          m_x, m_y, m_pos;
   bit          m_ovf, m_und, m_fs;

   tft_pixel_stream #(
      .WIDTH (WIDTH),
      .HEIGHT(HEIGHT),
      .DEPTH (DEPTH),
      .FILL  (FILL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .data_clk   (data_clk),
      .enable     (enable),
      .resync     (resync),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .clear_flags(clear_flags),
      .pixel_out  (pixel_out),
      .full       (full),
      .empty      (empty),
      .level      (level),
      .x          (x),
      .y          (y),
      .frame_start(frame_start),
      .overflow   (overflow),
      .underrun   (underrun)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".pixel"}, 32'(pixel_out), 32'(m_pix));
      chk({tag, ".x"}, 32'(x), m_x);
      chk({tag, ".y"}, 32'(y), m_y);
      chk({tag, ".level"}, 32'(level), mq.size());
      chk({tag, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
      chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
      chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
      chk({tag, ".underrun"}, 32'(underrun), 32'(m_und));
   endtask

   task automatic model_reset();
      mq.delete();
      m_pix = '0;
      m_x   = 0;
      m_y   = 0;
      m_pos = 0;
      m_ovf = 0;
      m_und = 0;
      m_fs  = 0;
   endtask

   task automatic do_write(input logic [15:0] d, input string tag);
      wr_en   = 1'b1;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
      if (mq.size() < DEPTH) mq.push_back(d);
      else m_ovf = 1;
      check_state(tag);
   endtask

   // One full data_clk period; optional write lands in the same cycle as the issue edge.
   task automatic do_strobe(input bit en, input bit wr, input logic [15:0] wd, input string tag);
      bit was_full;
      bit was_empty;
      enable   = en;
      data_clk = 1'b1;
      tick();
      tick();
      chk({tag, ".pre_pixel"}, 32'(pixel_out), 32'(m_pix));
      chk({tag, ".pre_fs"}, 32'(frame_start), 32'd0);
      wr_en   = wr;
      wr_data = wd;
      tick();
      wr_en     = 1'b0;
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      m_fs      = 0;
      if (en) begin
         if (was_empty) begin
            m_pix = FILL;
            m_und = 1;
         end else begin
            m_pix = mq.pop_front();
         end
         m_x   = m_pos % WIDTH;
         m_y   = (m_pos / WIDTH) % HEIGHT;
         m_fs  = (m_x == 0) && (m_y == 0);
         m_pos = (m_pos + 1) % (WIDTH * HEIGHT);
      end
      if (wr) begin
         if (!was_full) mq.push_back(wd);
         else m_ovf = 1;
      end
      check_state(tag);
      chk({tag, ".fs"}, 32'(frame_start), 32'(m_fs));
      tick();
      chk({tag, ".fs_end"}, 32'(frame_start), 32'd0);
      data_clk = 1'b0;
      repeat (4) tick();
   endtask

   task automatic do_clear(input string tag);
      clear_flags = 1'b1;
      tick();
      clear_flags = 1'b0;
      m_ovf = 0;
      m_und = 0;
      check_state(tag);
   endtask

   task automatic do_resync(input string tag);
      resync  = 1'b1;
      wr_en   = 1'b1;
      wr_data = 16'($urandom);
      tick();
      resync = 1'b0;
      wr_en  = 1'b0;
      mq.delete();
      m_pos = 0;
      check_state(tag);
   endtask

   initial begin
      rst = 1'b1;
      data_clk = 1'b0;
      enable = 1'b0;
      resync = 1'b0;
      wr_en = 1'b0;
      wr_data = '0;
      clear_flags = 1'b0;
      model_reset();
      tick();
      tick();
      rst = 1'b0;
      check_state("reset");
      chk("reset.fs", 32'(frame_start), 32'd0);

      // Basic pop of three primaries
      enable = 1'b1;
      do_write(16'hF800, "basic.wr0");
      do_write(16'h07E0, "basic.wr1");
      do_write(16'h001F, "basic.wr2");
      do_strobe(1'b1, 1'b0, '0, "basic.pop0");
      do_strobe(1'b1, 1'b0, '0, "basic.pop1");
      do_strobe(1'b1, 1'b0, '0, "basic.pop2");

      // Overflow with strobes gated off, then drain
      enable = 1'b0;
      for (int i = 0; i <= DEPTH; i++) begin
         do_write(16'h1000 + 16'(i), "ovf.wr");
      end
      for (int i = 0; i < DEPTH; i++) begin
         do_strobe(1'b1, 1'b0, '0, "ovf.pop");
      end
      do_clear("ovf.clear");

      // Underrun with a coincident write
      do_strobe(1'b1, 1'b1, 16'hABCD, "und.pop");
      do_strobe(1'b1, 1'b0, '0, "und.next");
      do_clear("und.clear");

      // Raster wrap from a cleared position
      do_resync("wrap.resync");
      for (int i = 0; i < 9; i++) begin
         do_strobe(1'b1, 1'b1, 16'(i * 3 + 1), "wrap.pop");
      end

      // Gating and resync
      do_resync("gate.flush");
      do_write(16'h1111, "gate.wr0");
      do_write(16'h2222, "gate.wr1");
      do_write(16'h3333, "gate.wr2");
      do_strobe(1'b0, 1'b0, '0, "gate.off0");
      do_strobe(1'b0, 1'b0, '0, "gate.off1");
      do_resync("gate.resync");
      do_strobe(1'b1, 1'b0, '0, "gate.fill");
      do_clear("gate.clear");

      // Randomized mix
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 5))
            0, 1: do_write(16'($urandom), "rnd.wr");
            2: do_strobe(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), "rnd.pop");
            3: do_strobe(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                         "rnd.gate");
            4: do_clear("rnd.clear");
            default: begin
               if ($urandom_range(0, 3) == 0) do_resync("rnd.resync");
               else do_write(16'($urandom), "rnd.wr2");
            end
         endcase
      end

      // Reset mid-frame discards contents and position
      do_write(16'hCAFE, "mid.wr");
      do_strobe(1'b1, 1'b0, '0, "mid.pop");
      do_write(16'hBEEF, "mid.wr2");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      check_state("mid.reset");
      do_write(16'h7777, "mid.wr3");
      do_strobe(1'b1, 1'b0, '0, "mid.after");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
